// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline latch; owns the PC and the I-memory request.
// Defining FETCH_STATS_EN adds a fetch_count output that counts valid IF/ID loads.
module fetch_stage #(
    parameter logic [31:0] PC0       = 32'h00000000,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {FETCH, HALT_PEND, HALTED} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] instr_next, npc_next;
    logic        valid_next;

    assign pc_plus4 = pc + 32'd4;
    assign imemaddr = pc;
    assign imemREN  = (state == FETCH) && !RST;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = ifid_instr;
        npc_next   = ifid_npc;
        valid_next = ifid_valid;
        if (halt) begin
            state_next = HALTED;
            instr_next = '0;
            npc_next   = '0;
            valid_next = 1'b0;
        end else if (state != HALTED) begin
            if (redirect) begin
                // Redirect wins over stall; any word returned this cycle is discarded.
                state_next = FETCH;
                pc_next    = {redirect_pc[31:2], 2'b00};
                instr_next = '0;
                npc_next   = '0;
                valid_next = 1'b0;
            end else if (flush) begin
                instr_next = '0;
                npc_next   = '0;
                valid_next = 1'b0;
                if (state == FETCH && !stall && ihit) begin
                    pc_next = pc_plus4;
                end
            end else if (stall) begin
                pc_next = pc;
            end else if (state == FETCH && ihit) begin
                pc_next    = pc_plus4;
                instr_next = imemload;
                npc_next   = pc_plus4;
                valid_next = 1'b1;
                if (imemload == HALT_WORD) begin
                    state_next = HALT_PEND;
                end
            end else begin
                instr_next = '0;
                npc_next   = '0;
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= FETCH;
            pc         <= PC0;
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ifid_instr <= instr_next;
            ifid_npc   <= npc_next;
            ifid_valid <= valid_next;
        end
    end

`ifdef FETCH_STATS_EN
    logic valid_load;

    // Only the ihit-advance path ever places a real instruction into IF/ID.
    assign valid_load = !halt && (state == FETCH) && !redirect && !flush && !stall && ihit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_count <= '0;
        end else if (valid_load) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline latch; directly upstream of control_unit decode, whose imemload input is ifid_instr.
- Owns the PC and drives the instruction-memory request (imemREN/imemaddr, ihit return).
- Accepts stall from the hazard unit and redirect/flush from branch/jump resolution.
- Stops speculative fetch past a halt instruction.

Parameters:
PC0, 32'h00000000, PC value loaded on reset
HALT_WORD, 32'hFFFFFFFF, instruction encoding treated as halt by fetch

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
ihit  in  1  imemload valid for imemaddr this cycle
imemload  in  32  instruction word from I-cache
imemREN  out  1  instruction read request
imemaddr  out  32  instruction address (= PC)
stall  in  1  hold PC and IF/ID (load-use or D-side wait)
redirect  in  1  load PC from redirect_pc (taken branch, J, JAL, JR)
redirect_pc  in  32  redirect target
flush  in  1  squash IF/ID contents to bubble
halt  in  1  halt committed downstream; stop permanently
ifid_instr  out  32  latched instruction (0 = bubble/nop)
ifid_npc  out  32  latched PC+4 of ifid_instr
ifid_valid  out  1  ifid_instr is a real fetched instruction

Behaviour:
- Reset is asynchronous and active-high; all state is clocked on rising CLK.
- Reset values: PC=PC0, state=FETCH, ifid_instr=0, ifid_npc=0, ifid_valid=0.
- Outputs: imemaddr=PC always; imemREN=1 only in FETCH with RST low.
- FSM states: FETCH, HALT_PEND, HALTED.
- Per-cycle priority: RST > halt > redirect > flush > stall > ihit advance > bubble.
- halt=1 (any state): next state HALTED; IF/ID loads bubble (instr 0, valid 0); PC holds.
- redirect=1 (FETCH or HALT_PEND): PC <= {redirect_pc[31:2],2'b00}; IF/ID loads bubble; any same-cycle imemload is discarded; next state FETCH. Redirect overrides stall.
- flush=1 without redirect: IF/ID loads bubble; PC behaves as the stall/ihit rules below.
- stall=1 (no halt/redirect/flush): PC and IF/ID hold all bits; the ihit word is dropped and refetched later.
- FETCH, ihit=1, no higher-priority event: PC <= PC+4, wrapping mod 2^32. IF/ID loads instr=imemload, npc=PC+4, valid=1. If imemload==HALT_WORD, next state is HALT_PEND.
- FETCH, ihit=0, no higher-priority event: PC holds; IF/ID loads bubble, so decode sees a nop.
- HALT_PEND: imemREN=0; PC holds; IF/ID loads bubble unless stall=1, in which case it holds.
  - Leaves only on redirect (to FETCH, handling an older mispredicted branch) or halt (to HALTED).
- HALTED: imemREN=0; PC and IF/ID frozen as bubble; exits only through RST.
- Reset mid-request: the outstanding ihit is ignored; the first request after RST deasserts is to PC0.
- Latency: fetch to IF/ID is 1 cycle after ihit; redirect to new imemaddr is 1 cycle.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds output port fetch_count (out, 32): count of IF/ID loads with valid=1.
  - Resets to 0; increments by 1 per valid load; wraps mod 2^32.
  - Holds on stall, bubble and halt.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, ihit=1, words 0x24010001,0x24020002 → imemaddr 0x0,0x4,0x8; ifid_instr 0x24010001 (npc 0x4) then 0x24020002 (npc 0x8); valid=1 each.
- ihit=0 for 2 cycles at PC=0x8 → imemaddr stays 0x8; ifid_instr=0, valid=0 both cycles; fetch resumes with ihit.
- stall=1 for 3 cycles, ihit=1, PC=0x10 → PC stays 0x10; IF/ID holds its prior value; on release, 0x10 is refetched.
- redirect=1, redirect_pc=0x00000103, stall=1, ihit=1 same cycle → next imemaddr 0x100; IF/ID bubble; the fetched word is discarded.
- Fetch 0xFFFFFFFF at 0x20 → IF/ID holds it; imemREN=0 next cycle; PC=0x24 holds. Then redirect to 0x40 → FETCH at 0x40. Then halt=1 → HALTED; imemREN=0 until RST.
- FETCH_STATS_EN defined, 5 valid fetches with 2 bubbles and 1 stall between → fetch_count=5; RST asserted mid-run → fetch_count=0 asynchronously.
